// File: rtl/sam_ctrl_if.sv
// Port bundle for sam_ctrl: serial line and mode in, decoded message and status out.
interface sam_ctrl_if #(
  parameter int unsigned MSG_W = 8
);
  logic             mode;
  logic             str;
  logic [MSG_W-1:0] msg;
  logic             frame;
  logic             cfg_valid;
  logic             busy;
  logic             parity_err;

  modport master (
    output mode, str,
    input  msg, frame, cfg_valid, busy, parity_err
  );

  modport slave (
    input  mode, str,
    output msg, frame, cfg_valid, busy, parity_err
  );
endinterface

// File: rtl/sam_ctrl.sv
// SAM sequencing controller: serial config load, per-bit skip/sample majority vote, msg framing.
// Define SAM_PARITY_EN to add an even-parity window after the data bits of each message.
module sam_ctrl #(
  parameter int unsigned MSG_W = 8,
  parameter int unsigned D_W   = 8,
  parameter int unsigned S_W   = 8
) (
  input logic       clk,
  input logic       reset,
  sam_ctrl_if.slave bus
);
  localparam int unsigned CFG_W = 4 + D_W + S_W;
  localparam int unsigned CC_W  = $clog2(CFG_W);
  localparam int unsigned IDX_W = $clog2(MSG_W + 2);
  localparam int unsigned CNT_W = (D_W > S_W) ? D_W : S_W;
  localparam int unsigned OW    = S_W + 1;
  localparam int unsigned VW    = S_W + 2;
`ifdef SAM_PARITY_EN
  localparam int unsigned SR_W  = MSG_W;
`else
  // The final data bit goes straight into msg, so one bit less of history is enough.
  localparam int unsigned SR_W  = MSG_W - 1;
`endif

  typedef enum logic [1:0] {StIdle, StSkip, StSample, StEmit} state_e;

  state_e           state_q, first_st;
  logic [CFG_W-2:0] cfg_sr_q;
  logic [CC_W-1:0]  cfg_cnt_q;
  logic [CFG_W-1:0] cfg_word;
  logic [3:0]       n_q;
  logic [D_W-1:0]   d_q;
  logic [S_W-1:0]   ns_q, ns_eff;
  logic             cfg_valid_q;
  logic [CNT_W-1:0] win_q, win_inc;
  logic [OW-1:0]    ones_q, ones_nx;
  logic [IDX_W-1:0] bit_idx_q, idx_inc, n_eff;
  logic [SR_W-1:0]  bit_sr_q;
  logic [MSG_W-1:0] msg_q;
  logic             frame_q, busy_q;
  logic             bit_dec, skip_done, samp_done;
`ifdef SAM_PARITY_EN
  logic             par_err_q;
`endif

  always_comb begin
    cfg_word  = {cfg_sr_q, bus.str};
    n_eff     = (n_q == 4'd0 || 32'(n_q) > MSG_W) ? IDX_W'(MSG_W) : IDX_W'(n_q);
    ns_eff    = (ns_q == '0) ? S_W'(1) : ns_q;
    first_st  = (d_q == '0) ? StSample : StSkip;
    win_inc   = win_q + 1'b1;
    idx_inc   = bit_idx_q + 1'b1;
    skip_done = (win_inc == CNT_W'(d_q));
    samp_done = (win_inc == CNT_W'(ns_eff));
    ones_nx   = ones_q + OW'(bus.str);
    // Strict majority: a tie decodes as 0.
    bit_dec   = ((VW'(ones_nx) << 1) > VW'(ns_eff));
  end

  // Configuration shifter runs independently of the decode FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_sr_q    <= '0;
      cfg_cnt_q   <= '0;
      n_q         <= '0;
      d_q         <= '0;
      ns_q        <= '0;
      cfg_valid_q <= 1'b0;
    end else if (bus.mode) begin
      cfg_sr_q <= cfg_word[CFG_W-2:0];
      if (cfg_cnt_q == CC_W'(CFG_W - 1)) begin
        n_q         <= cfg_word[CFG_W-1 -: 4];
        d_q         <= cfg_word[S_W +: D_W];
        ns_q        <= cfg_word[S_W-1:0];
        cfg_valid_q <= 1'b1;
        cfg_cnt_q   <= '0;
      end else begin
        cfg_cnt_q <= cfg_cnt_q + 1'b1;
      end
    end else begin
      cfg_cnt_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      win_q     <= '0;
      ones_q    <= '0;
      bit_idx_q <= '0;
      bit_sr_q  <= '0;
      msg_q     <= '0;
      frame_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SAM_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      frame_q <= 1'b0;
`ifdef SAM_PARITY_EN
      par_err_q <= 1'b0;
`endif
      if (bus.mode) begin
        // Abort: partial message dropped, msg held.
        state_q <= StIdle;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle, StEmit: begin
            if (state_q == StEmit || cfg_valid_q) begin
              state_q   <= first_st;
              busy_q    <= 1'b1;
              win_q     <= '0;
              ones_q    <= '0;
              bit_idx_q <= '0;
              bit_sr_q  <= '0;
            end
          end
          StSkip: begin
            if (skip_done) begin
              state_q <= StSample;
              win_q   <= '0;
            end else begin
              win_q <= win_inc;
            end
          end
          StSample: begin
            if (samp_done) begin
              win_q     <= '0;
              ones_q    <= '0;
              bit_idx_q <= idx_inc;
`ifdef SAM_PARITY_EN
              if (bit_idx_q == n_eff) begin
                state_q <= StEmit;
                busy_q  <= 1'b0;
                if (^{bit_sr_q, bit_dec}) begin
                  par_err_q <= 1'b1;
                end else begin
                  frame_q <= 1'b1;
                  msg_q   <= bit_sr_q;
                end
              end else begin
                bit_sr_q <= {bit_sr_q[SR_W-2:0], bit_dec};
                state_q  <= first_st;
              end
`else
              bit_sr_q <= {bit_sr_q[SR_W-2:0], bit_dec};
              if (idx_inc < n_eff) begin
                state_q <= first_st;
              end else begin
                state_q <= StEmit;
                busy_q  <= 1'b0;
                frame_q <= 1'b1;
                msg_q   <= {bit_sr_q, bit_dec};
              end
`endif
            end else begin
              ones_q <= ones_nx;
              win_q  <= win_inc;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.msg       = msg_q;
  assign bus.frame     = frame_q;
  assign bus.cfg_valid = cfg_valid_q;
  assign bus.busy      = busy_q;
`ifdef SAM_PARITY_EN
  assign bus.parity_err = par_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sam_ctrl.sv
// Directed self-checking bench for sam_ctrl: reset, config load, decode, boundaries, abort.
module tb_sam_ctrl;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  sam_ctrl_if #(.MSG_W(8)) bus ();

  sam_ctrl #(.MSG_W(8), .D_W(8), .S_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cfg(input logic [3:0] n, input logic [7:0] d, input logic [7:0] s);
    logic [19:0] w;
    w = {n, d, s};
    for (int i = 19; i >= 0; i--) begin
      bus.mode = 1'b1;
      bus.str  = w[i];
      tick();
    end
    bus.mode = 1'b0;
  endtask

  // One bit window: d skip cycles (str driven high to prove it is ignored), then n samples MSB-first.
  task automatic drive_bit(input int d, input int n, input logic [7:0] s);
    chk("busy_in_bit", {31'd0, bus.busy}, 32'd1);
    chk("no_frame_in_bit", {31'd0, bus.frame}, 32'd0);
    for (int i = 0; i < d; i++) begin
      bus.str = 1'b1;
      tick();
    end
    for (int i = 0; i < n; i++) begin
      bus.str = s[7-i];
      tick();
    end
  endtask

  task automatic par_win(input int d, input int n, input logic p);
`ifdef SAM_PARITY_EN
    drive_bit(d, n, p ? 8'hFF : 8'h00);
`else
    if (p === 1'bx) $display("parity argument unknown");
`endif
  endtask

  task automatic entry();
    bus.mode = 1'b0;
    bus.str  = 1'b1;
    tick();
  endtask

  task automatic frame_chk(input string tag, input logic [7:0] exp_msg);
    chk({tag, "_frame"}, {31'd0, bus.frame}, 32'd1);
    chk({tag, "_msg"}, {24'd0, bus.msg}, {24'd0, exp_msg});
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_perr"}, {31'd0, bus.parity_err}, 32'd0);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    bus.mode = 1'b0;
    bus.str  = 1'b0;

    // Reset with random mode/str
    for (int i = 0; i < 3; i++) begin
      bus.mode = 1'($urandom_range(0, 1));
      bus.str  = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rst_msg", {24'd0, bus.msg}, 32'h00);
    chk("rst_frame", {31'd0, bus.frame}, 32'd0);
    chk("rst_cfg_valid", {31'd0, bus.cfg_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_perr", {31'd0, bus.parity_err}, 32'd0);
    reset    = 1'b0;
    bus.mode = 1'b0;
    bus.str  = 1'b1;
    tick();
    tick();
    chk("idle_no_cfg_busy", {31'd0, bus.busy}, 32'd0);

    // Config load n=4 d=2 N=3: cfg_valid only after the 20th bit
    begin
      logic [19:0] w;
      w = {4'd4, 8'd2, 8'd3};
      for (int i = 19; i >= 1; i--) begin
        bus.mode = 1'b1;
        bus.str  = w[i];
        tick();
      end
      chk("cfg_19_bits", {31'd0, bus.cfg_valid}, 32'd0);
      bus.str = w[0];
      tick();
      chk("cfg_20_bits", {31'd0, bus.cfg_valid}, 32'd1);
      chk("cfg_idle_busy", {31'd0, bus.busy}, 32'd0);
    end

    // Decode 1010 then back-to-back 0101
    entry();
    drive_bit(2, 3, 8'b110_00000);
    drive_bit(2, 3, 8'b001_00000);
    drive_bit(2, 3, 8'b111_00000);
    drive_bit(2, 3, 8'b010_00000);
    par_win(2, 3, 1'b0);
    frame_chk("dec_a", 8'h0A);
    tick();
    chk("frame_one_cycle", {31'd0, bus.frame}, 32'd0);
    drive_bit(2, 3, 8'b000_00000);
    drive_bit(2, 3, 8'b111_00000);
    drive_bit(2, 3, 8'b000_00000);
    drive_bit(2, 3, 8'b111_00000);
    par_win(2, 3, 1'b0);
    frame_chk("dec_b", 8'h05);
    tick();
    drive_bit(2, 3, 8'b111_00000);
    drive_bit(2, 3, 8'b111_00000);
    chk("msg_held_midframe", {24'd0, bus.msg}, 32'h05);

    // Abort mid-frame with 5 cycles of mode=1 (partial config discarded)
    bus.mode = 1'b1;
    bus.str  = 1'b0;
    tick();
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("abort_frame", {31'd0, bus.frame}, 32'd0);
    chk("abort_msg_held", {24'd0, bus.msg}, 32'h05);
    chk("abort_cfg_valid", {31'd0, bus.cfg_valid}, 32'd1);
    entry();
    drive_bit(2, 3, 8'b111_00000);
    drive_bit(2, 3, 8'b000_00000);
    drive_bit(2, 3, 8'b000_00000);
    drive_bit(2, 3, 8'b111_00000);
    par_win(2, 3, 1'b0);
    frame_chk("restart", 8'h09);
    tick();
    chk("restart_frame_drop", {31'd0, bus.frame}, 32'd0);

    // n=2 d=0 N=4: tie decodes as 0, three of four as 1
    send_cfg(4'd2, 8'd0, 8'd4);
    entry();
    drive_bit(0, 4, 8'b1100_0000);
    drive_bit(0, 4, 8'b1110_0000);
    par_win(0, 4, 1'b1);
    frame_chk("tie", 8'h01);

    // n=0 d=0 N=0 -> 8 bits, 1 sample each, str high
    send_cfg(4'd0, 8'd0, 8'd0);
    entry();
    for (int i = 0; i < 8; i++) drive_bit(0, 1, 8'hFF);
    par_win(0, 1, 1'b0);
    frame_chk("zero_cfg_a", 8'hFF);
    bus.str = 1'b1;
    tick();
    chk("zero_cfg_gap", {31'd0, bus.frame}, 32'd0);
    for (int i = 0; i < 8; i++) drive_bit(0, 1, 8'hFF);
    par_win(0, 1, 1'b0);
    frame_chk("zero_cfg_b", 8'hFF);

    // Reset mid-frame clears config too
    tick();
    drive_bit(0, 1, 8'hFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_cfg_valid", {31'd0, bus.cfg_valid}, 32'd0);
    chk("midrst_msg", {24'd0, bus.msg}, 32'h00);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    bus.mode = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("midrst_stay_idle", {31'd0, bus.busy}, 32'd0);

`ifdef SAM_PARITY_EN
    send_cfg(4'd4, 8'd2, 8'd3);
    entry();
    drive_bit(2, 3, 8'b110_00000);
    drive_bit(2, 3, 8'b001_00000);
    drive_bit(2, 3, 8'b111_00000);
    drive_bit(2, 3, 8'b010_00000);
    drive_bit(2, 3, 8'b111_00000);
    chk("par_bad_err", {31'd0, bus.parity_err}, 32'd1);
    chk("par_bad_frame", {31'd0, bus.frame}, 32'd0);
    chk("par_bad_msg", {24'd0, bus.msg}, 32'h00);
    tick();
    chk("par_err_strobe", {31'd0, bus.parity_err}, 32'd0);
    drive_bit(2, 3, 8'b110_00000);
    drive_bit(2, 3, 8'b001_00000);
    drive_bit(2, 3, 8'b111_00000);
    drive_bit(2, 3, 8'b010_00000);
    drive_bit(2, 3, 8'b000_00000);
    frame_chk("par_good", 8'h0A);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sam_ctrl.md
Name: sam_ctrl

Overview:
Sequencing controller for the serial sampling message (SAM) decoder path. It loads the serial configuration word (n, d, N) from str while mode=1. While mode=0 it schedules per-bit skip and sample windows, majority-votes each bit, and assembles msg. It emits a one-cycle frame strobe per decoded message and sits between the serial line front-end and message consumers.

Parameters:
MSG_W, 8, maximum message bits; msg width
D_W, 8, width of skip count d
S_W, 8, width of samples-per-bit N

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
mode  input  1  1 = configuration load, 0 = normal decode
str  input  1  serial data line, sampled every posedge
msg  output  MSG_W  last decoded message, right-aligned, first bit in MSB of used field
frame  output  1  one-cycle strobe: msg updated this cycle
cfg_valid  output  1  a complete configuration has been loaded
busy  output  1  decode in progress (SKIP or SAMPLE state)
parity_err  output  1  one-cycle strobe on parity mismatch (tied 0 without SAM_PARITY_EN)

Behaviour:
- Reset (reset=1 at posedge): msg=0, frame=0, cfg_valid=0, busy=0, parity_err=0, state=IDLE, all counters=0, n_r=0, d_r=0, N_r=0.
- Config word is 4+D_W+S_W bits (20 at defaults), MSB first: n[3:0], then d, then N.
- Every posedge with mode=1: shift str into cfg_sr and increment cfg_cnt. The first cycle mode is seen high carries bit 0.
- On the edge capturing the last bit (cfg_cnt=19): n_r/d_r/N_r <= {cfg_sr,str} fields, cfg_valid<=1, cfg_cnt<=0. Further bits start a new word.
- mode=0 clears cfg_cnt. A partial word is discarded; the previous config and cfg_valid are unchanged.
- Effective values: n_eff = (n_r==0 or n_r>MSG_W) ? MSG_W : n_r; N_eff = (N_r==0) ? 1 : N_r; d_r=0 means no skip.
- FSM states: IDLE, SKIP, SAMPLE, EMIT.
- IDLE -> SKIP (or SAMPLE if d_r=0) at the first edge with mode=0 and cfg_valid=1. That cycle is not sampled.
- SKIP: lasts exactly d_r cycles; str ignored.
- SAMPLE: lasts exactly N_eff cycles; ones counter adds str each cycle.
- Bit decision at the end of SAMPLE: bit = (2*ones > N_eff). A tie decodes as 0. Counter width is S_W+1, with no overflow.
- Bit is shifted into bit_sr and bit_idx increments. If bit_idx < n_eff, the next bit starts (SKIP or SAMPLE); otherwise go to EMIT.
- EMIT (1 cycle): msg <= bit_sr zero-extended; frame=1 for this cycle. Next state is SKIP/SAMPLE immediately, so frames run back to back.
- Frame period is n_eff*(d_r+N_eff)+1 cycles.
- busy=1 in SKIP and SAMPLE, 0 in IDLE and EMIT.
- mode=1 in any non-IDLE state: abort to IDLE at that edge. The partial message is discarded, msg is held, and no frame is issued. The config load proceeds simultaneously.
- Reset mid-frame or mid-config: everything returns to reset values, including cfg_valid=0.
- A new config completing while decoding cannot happen, because decoding requires mode=0.

Optional Feature:
SAM_PARITY_EN
- Defined: after n_eff data bits, one extra SKIP+SAMPLE window decodes an even-parity bit. In EMIT, if XOR(data bits, parity bit)=0, frame=1 and msg updates. Otherwise parity_err=1, frame=0, and msg is held. Frame period grows by d_r+N_eff.
- Undefined: no parity window; parity_err is constant 0.

Test Plan:
- Reset: hold reset=1 for 3 cycles with random mode/str -> msg=0x00, frame=0, cfg_valid=0, busy=0.
- Config load: mode=1, send 0100_00000010_00000011 (n=4, d=2, N=3) -> cfg_valid=1 after the 20th edge; n_r=4, d_r=2, N_r=3.
- Decode: mode=0, per bit 2 skip cycles then samples 110,001,111,010 -> bits 1,0,1,0; msg=0x0A. frame high exactly one cycle, 21 cycles after decode entry (4*5+1); back-to-back frames every 21 cycles.
- Boundaries: n=0, N=0, d=0 config; str=1 constant -> msg=0xFF every 9 cycles. N=4 with two ones -> tie -> bit 0.
- Abort and partial config: mode pulses to 1 for 5 cycles mid-frame -> no frame, msg held, cfg_valid stays 1, old config retained, decode restarts from bit 0.
- SAM_PARITY_EN: n=4, data 1,0,1,0 then parity 1 -> parity_err=1, frame=0, msg held. Repeat with parity 0 -> frame=1, msg=0x0A.
